// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Computes a 4*NIBBLES-bit sum A + B + carry_in by driving one 4-bit adder
//   slice (adder4) once per clock, least-significant nibble first. The carry
//   between nibbles lives in a register. Operands arrive and the result
//   leaves over valid/ready handshakes.
//
// Ports (nibble_serial_adder):
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair and carry_in are valid
//   in_ready   block is idle and can accept an operation
//   a, b       W-bit operands (unsigned or two's complement), W = 4*NIBBLES
//   carry_in   carry into nibble 0
//   out_valid  sum / carry_out / overflow are valid
//   out_ready  consumer accepts the result
//   sum        A + B + carry_in modulo 2^W
//   carry_out  unsigned carry out of bit W-1
//   overflow   signed overflow of the W-bit addition
//   busy       high while nibbles are being processed
//
// Ports (adder4): 4-bit slice, {carry_out, result} = a + b + carry_in.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] result,
  output logic       carry_out
);

  assign {carry_out, result} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   carry_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            a_sign_q, b_sign_q;
  logic            carry_out_q, overflow_q;

  logic [3:0]      nib_result;
  logic            nib_carry;
  logic            last_nibble;
  logic [W-1:0]    sum_shifted;

  // The only adder on the sum path: low nibbles of the operand shift
  // registers plus the inter-nibble carry.
  adder4 u_adder4 (
    .a         (a_q[3:0]),
    .b         (b_q[3:0]),
    .carry_in  (carry_q),
    .result    (nib_result),
    .carry_out (nib_carry)
  );

  assign last_nibble = (cnt_q == CW'(NIBBLES - 1));

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the
  // bottom. Written as shift/or so NIBBLES=1 needs no special slicing.
  assign sum_shifted = (sum_q >> 4) | (W'(nib_result) << (W - 4));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nibble) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Everything is cleared on reset because the reset values of
  // sum, carry_out and overflow are observable on the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= carry_in;
            cnt_q    <= '0;
            // Sign bits are kept aside: the operand registers shift them out.
            a_sign_q <= a[W-1];
            b_sign_q <= b[W-1];
          end
        end
        RUN: begin
          sum_q   <= sum_shifted;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= nib_carry;
          cnt_q   <= cnt_q + CW'(1);
          if (last_nibble) begin
            carry_out_q <= nib_carry;
            // The top nibble's MSB is the sum sign bit.
            overflow_q  <= (a_sign_q == b_sign_q) && (nib_result[3] != a_sign_q);
          end
        end
        default: ;  // DONE: hold the result until the handshake.
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: a 4-nibble instance exercised with
// directed and random operations plus a 1-nibble instance swept over all
// 512 input combinations. Expected values come from plain integer
// arithmetic on the operands.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-nibble instance
  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
  logic        cout4, ovf4, busy4;
  logic [15:0] a4, b4, sum4;

  // 1-nibble instance
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1;
  logic        cout1, ovf1, busy1;
  logic [3:0]  a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .carry_in  (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .carry_out (cout4),
    .overflow  (ovf4),
    .busy      (busy4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .carry_in  (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .carry_out (cout1),
    .overflow  (ovf1),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: full-precision unsigned sum, and signed overflow judged by
  // whether the true signed result fits in 16 bits.
  function automatic logic [16:0] ref_sum(logic [15:0] a, logic [15:0] b, logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  function automatic logic ref_ovf(logic [15:0] a, logic [15:0] b, logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
    return (s > 32767) || (s < -32768);
  endfunction

  // Offer an operation to dut4 and wait for out_valid; checks latency.
  task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input string tag);
    int n;
    n = 0;
    while (!in_ready4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, 32'(in_ready4), 32'(1));
    a4 = a; b4 = b; cin4 = c; in_valid4 = 1'b1;
    @(negedge clk);  // acceptance edge has passed
    in_valid4 = 1'b0;
    check({tag, " busy"}, 32'(busy4), 32'(1));
    check({tag, " in_ready low"}, 32'(in_ready4), 32'(0));
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(4));
  endtask

  task automatic result4(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input string tag);
    logic [16:0] e;
    e = ref_sum(a, b, c);
    check({tag, " sum"}, 32'(sum4), 32'(e[15:0]));
    check({tag, " carry_out"}, 32'(cout4), 32'(e[16]));
    check({tag, " overflow"}, 32'(ovf4), 32'(ref_ovf(a, b, c)));
  endtask

  // Complete operation with out_ready already high.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                     input string tag);
    start4(a, b, c, tag);
    result4(a, b, c, tag);
    @(negedge clk);  // handshake edge has passed
    check({tag, " out_valid drop"}, 32'(out_valid4), 32'(0));
    check({tag, " back to idle"}, 32'(in_ready4), 32'(1));
  endtask

  initial begin
    logic [15:0] sa, sb;
    logic        sc;
    int          n;
    logic [4:0]  e1;

    rst = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset in_ready", 32'(in_ready4), 32'(1));
    check("reset out_valid", 32'(out_valid4), 32'(0));
    check("reset busy", 32'(busy4), 32'(0));
    check("reset sum", 32'(sum4), 32'(0));
    check("reset carry_out", 32'(cout4), 32'(0));
    check("reset overflow", 32'(ovf4), 32'(0));
    check("reset n1 in_ready", 32'(in_ready1), 32'(1));
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    op4(16'h1234, 16'h4321, 1'b1, "basic");
    check("basic const sum", 32'(ref_sum(16'h1234, 16'h4321, 1'b1)), 32'h5556);
    op4(16'hFFFF, 16'h0001, 1'b0, "ripple");
    op4(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    op4(16'h8000, 16'h8000, 1'b0, "neg_ovf");
    op4(16'h7FFF, 16'h0000, 1'b1, "cin_ovf");

    // Backpressure: result held, new operands ignored
    out_ready4 = 1'b0;
    sa = 16'hA5C3; sb = 16'h6B2E; sc = 1'b1;
    start4(sa, sb, sc, "stall");
    for (int k = 0; k < 10; k++) begin
      in_valid4 = k[0];
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      @(negedge clk);
      result4(sa, sb, sc, "stall hold");
      check("stall in_ready", 32'(in_ready4), 32'(0));
      check("stall out_valid", 32'(out_valid4), 32'(1));
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    check("stall release", 32'(out_valid4), 32'(0));
    check("stall idle", 32'(in_ready4), 32'(1));
    @(negedge clk);
    check("stall no ghost op", 32'(busy4), 32'(0));

    // Reset mid-operation (second RUN cycle)
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready4), 32'(1));
    check("abort out_valid", 32'(out_valid4), 32'(0));
    check("abort sum", 32'(sum4), 32'(0));
    check("abort busy", 32'(busy4), 32'(0));
    op4(16'h0F0F, 16'h00F1, 1'b0, "after_abort");

    // Reset while a result is pending
    out_ready4 = 1'b0;
    start4(16'h0123, 16'h0456, 1'b0, "done_rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready4 = 1'b1;
    check("done_rst out_valid", 32'(out_valid4), 32'(0));
    check("done_rst in_ready", 32'(in_ready4), 32'(1));

    // Random operations
    for (int k = 0; k < 20; k++) begin
      op4(16'($urandom), 16'($urandom), 1'($urandom), "random");
    end

    // NIBBLES=1: all {carry_in, b, a}
    for (int i = 0; i < 512; i++) begin
      a1 = i[3:0]; b1 = i[7:4]; cin1 = i[8]; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("n1 latency", 32'(n), 32'(1));
      e1 = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
      check("n1 sum", 32'({cout1, sum1}), 32'(e1));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential multi-word adder that computes a NIBBLES×4-bit sum by driving a single `adder4` instance one nibble per clock, least-significant nibble first. It chains the carry through a register between nibbles. It sits directly upstream of `adder4`: it supplies that block's `a`, `b` and `carry_in`, and consumes its `result` and `carry_out`. Operands enter and the sum leaves over valid/ready handshakes, so the block can sit between wider datapath stages.

## Interface

- NIBBLES, 4, number of 4-bit slices per operand; legal range 1–16; operand width W = 4·NIBBLES.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair and carry_in are valid.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- carry_in  input  1  carry into nibble 0.
- out_valid  output  1  sum, carry_out and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  A + B + carry_in, modulo 2^W.
- carry_out  output  1  unsigned carry out of bit W-1.
- overflow  output  1  signed overflow of the W-bit addition.
- busy  output  1  high in RUN state.

## Operation

- Exactly one `adder4` instance, ports `a`, `b`, `carry_in`, `result`, `carry_out`; no other adder logic on the sum path.
- FSM states:
  - IDLE (in_ready=1).
  - RUN (busy=1).
  - DONE (out_valid=1).
- IDLE → RUN on in_valid && in_ready.
  - Latch a, b into shift registers.
  - Latch carry_in into the carry register.
  - Clear the nibble counter to 0.
- In RUN, each cycle:
  - The `adder4` inputs are the low nibble of each operand register plus the carry register.
  - The `adder4` result is shifted into the top nibble of the sum register; the operand registers shift right by 4.
  - The carry register takes the `adder4` carry_out.
  - The counter increments.
- RUN → DONE on the edge that processes nibble NIBBLES-1 (counter == NIBBLES-1).
  - carry_out takes the final `adder4` carry_out.
  - overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), using the latched operand sign bits.
- DONE → IDLE on out_ready. sum, carry_out and overflow are held stable until that edge.
- in_ready is high only in IDLE. Inputs presented in RUN or DONE are ignored; the operation in flight is unaffected.
- The block accepts no new operation in DONE, even when out_ready is high in the same cycle. The next acceptance happens one cycle after the handshake.
- Arithmetic: {carry_out, sum} equals a + b + carry_in, computed at W+1 bits, exactly.
- NIBBLES=1 degenerates to a single RUN cycle; the result must equal `adder4` combinationally applied.

## Timing

- Reset values, all outputs:
  - State IDLE, so in_ready=1.
  - out_valid=0, busy=0.
  - sum=0, carry_out=0, overflow=0.
  - Counter and carry register cleared.
- Latency: acceptance on edge E0. Nibble k is processed on edge E(k+1). out_valid rises after edge E(NIBBLES): NIBBLES cycles after acceptance.
- Throughput without backpressure: one operation per NIBBLES+2 cycles (accept, NIBBLES RUN, DONE handshake).
- out_valid, once asserted, stays high until the cycle after out_ready is sampled high. Outputs do not change while out_valid && !out_ready.
- rst wins over every other event in the same cycle.
  - Reset in RUN aborts the operation; no result is produced.
  - Reset in DONE discards the pending result; out_valid falls on the next edge.
- in_valid held high continuously: only one acceptance per pass through IDLE; no duplicate operations.

## Test plan

- NIBBLES=4, a=0x1234, b=0x4321, carry_in=1 -> sum=0x5556, carry_out=0, overflow=0; out_valid exactly 4 cycles after acceptance.
- NIBBLES=4, a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0 (carry ripples through all four nibbles).
- NIBBLES=4, a=0x7FFF, b=0x0001, carry_in=0 -> sum=0x8000, carry_out=0, overflow=1. Also a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum/carry_out/overflow constant and in_ready=0 throughout. in_valid toggled with new operands during the stall -> ignored. Result released on the first out_ready=1 cycle.
- Reset mid-operation: assert rst for 1 cycle at the second RUN cycle -> next cycle IDLE with in_ready=1, out_valid=0, sum=0. A following operation 0x0F0F+0x00F1, carry_in=0 -> 0x1000, carry_out=0.
- NIBBLES=1 exhaustive: all 512 combinations of {carry_in, b, a} -> {carry_out, sum} == a + b + carry_in, with zero mismatches.
